// File: rtl/kronos_types.sv
// Shared constants and state encoding for the Kronos instruction-memory responder.
package kronos_types;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } imem_state_e;

endpackage

// File: rtl/kronos_spram.sv
// Single-port synchronous RAM, one-cycle read latency, array never reset.
module kronos_spram #(
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end else begin
        rdata <= r_mem[addr];
      end
    end
  end

endmodule

// File: rtl/kronos_instr_mem.sv
// Fetch-side responder: serves instruction words from on-chip RAM with optional
// wait states, and accepts program-load writes whenever the fetch path is idle.
module kronos_instr_mem
    import kronos_types::*;
#(
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 0,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic        instr_gnt,
    output logic [31:0] instr_data,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_rdy
);

    localparam int AW = $clog2(DEPTH);

    imem_state_e    r_state;
    imem_state_e    w_next;
    logic [3:0]     r_cnt;
    logic [3:0]     w_cnt_next;
    logic [31:0]    r_hold;
    logic [31:0]    r_data;
    logic           w_ram_en;
    logic           w_ram_we;
    logic [AW-1:0]  w_ram_addr;
    logic [31:0]    w_rdata;
    logic           w_unused;

    // Upper address bits wrap and the byte offset is ignored.
    assign w_unused = ^{instr_addr[31:AW+2], instr_addr[1:0],
                        load_addr[31:AW+2], load_addr[1:0]};

    // Loads win over a pending fetch; the fetch index is captured by the RAM read itself.
    assign w_ram_en   = (r_state == IDLE) && (load_en || instr_req);
    assign w_ram_we   = load_en;
    assign w_ram_addr = load_en ? load_addr[AW+1:2] : instr_addr[AW+1:2];

    kronos_spram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (w_ram_en),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (load_data),
        .rdata (w_rdata)
    );

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (!load_en && instr_req) begin
                    w_next = READ;
                end
            end
            READ: begin
                if (LATENCY == 0) begin
                    w_next = RESP;
                end else begin
                    w_next     = WAIT;
                    w_cnt_next = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_hold  <= NOP_INSTR;
            r_data  <= NOP_INSTR;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == READ) begin
                r_hold <= w_rdata;
            end
            // The visible word only changes on the edge into the grant cycle.
            if (w_next == RESP) begin
                r_data <= (r_state == READ) ? w_rdata : r_hold;
            end
        end
    end

    assign instr_gnt  = (r_state == RESP);
    assign instr_data = r_data;
    assign load_rdy   = (r_state == IDLE) && rstz;

    a_gnt_single: assert property (@(posedge clk) disable iff (!rstz)
        instr_gnt |=> !instr_gnt)
        else $error("instr_gnt high on two consecutive cycles");

    a_req_held: assert property (@(posedge clk) disable iff (!rstz)
        ((r_state == READ) || (r_state == WAIT)) |-> instr_req)
        else $error("instr_req dropped before instr_gnt");

    a_gnt_after_req: assert property (@(posedge clk) disable iff (!rstz)
        instr_gnt |-> (($past(r_state) == READ) || ($past(r_state) == WAIT)))
        else $error("instr_gnt without a sampled request");

endmodule

// File: tb/tb_kronos_instr_mem.sv
// Bench for kronos_instr_mem: three instances (LATENCY 0, 3, 5) checked against
// a word-array memory model and the request-to-grant timing rule.
module tb_kronos_instr_mem;
    import kronos_types::*;

    localparam int ND  = 3;
    localparam int DEP = 1024;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstz  [ND];
    logic [31:0] iaddr [ND];
    logic        req   [ND];
    logic        gnt   [ND];
    logic [31:0] idata [ND];
    logic        len   [ND];
    logic [31:0] laddr [ND];
    logic [31:0] ldata [ND];
    logic        lrdy  [ND];

    kronos_instr_mem #(.DEPTH(DEP), .LATENCY(0), .INIT_FILE("")) u_l0 (
        .clk(clk), .rstz(rstz[0]), .instr_addr(iaddr[0]), .instr_req(req[0]),
        .instr_gnt(gnt[0]), .instr_data(idata[0]), .load_en(len[0]),
        .load_addr(laddr[0]), .load_data(ldata[0]), .load_rdy(lrdy[0]));

    kronos_instr_mem #(.DEPTH(DEP), .LATENCY(3), .INIT_FILE("")) u_l3 (
        .clk(clk), .rstz(rstz[1]), .instr_addr(iaddr[1]), .instr_req(req[1]),
        .instr_gnt(gnt[1]), .instr_data(idata[1]), .load_en(len[1]),
        .load_addr(laddr[1]), .load_data(ldata[1]), .load_rdy(lrdy[1]));

    kronos_instr_mem #(.DEPTH(DEP), .LATENCY(5), .INIT_FILE("")) u_l5 (
        .clk(clk), .rstz(rstz[2]), .instr_addr(iaddr[2]), .instr_req(req[2]),
        .instr_gnt(gnt[2]), .instr_data(idata[2]), .load_en(len[2]),
        .load_addr(laddr[2]), .load_data(ldata[2]), .load_rdy(lrdy[2]));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem_m  [ND][DEP];
    logic [31:0] last_m [ND];

    typedef struct {
        bit          is_load;
        logic [31:0] addr;
        logic [31:0] data;
        bit          b2b;
    } vec_t;

    vec_t tbl [10];

    function automatic int lat(input int d);
        if (d == 0) return 0;
        if (d == 1) return 3;
        return 5;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic load(input int d, input logic [31:0] a, input logic [31:0] dat);
        int w;
        w = 0;
        @(negedge clk);
        len[d] = 1'b1; laddr[d] = a; ldata[d] = dat;
        while (!lrdy[d] && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!lrdy[d]) begin
            chk("load ready timeout", {31'b0, lrdy[d]}, 32'd1);
        end else begin
            @(negedge clk);
            mem_m[d][widx(a)] = dat;
        end
        len[d] = 1'b0;
    endtask

    // Ends at the grant cycle's falling edge with req dropped; b2b starts the new
    // request in that very cycle, as a core issuing its next fetch immediately would.
    task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] exp,
                         input bit b2b, input string nm);
        int          k;
        logic [31:0] seen;
        if (!b2b) begin
            @(negedge clk);
            chk({nm, " gnt width"}, {31'b0, gnt[d]}, 32'd0);
        end
        req[d] = 1'b1; iaddr[d] = a;
        k = 0;
        seen = last_m[d];
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (gnt[d]) break;
            if (idata[d] !== last_m[d]) seen = idata[d];
        end
        chk({nm, " latency"}, k, 2 + lat(d) + (b2b ? 1 : 0));
        chk({nm, " data"}, idata[d], exp);
        chk({nm, " hold"}, seen, last_m[d]);
        last_m[d] = exp;
        req[d] = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic        prev_fetch;
        logic [31:0] a;
        logic        stale;

        for (int d = 0; d < ND; d++) begin
            rstz[d] = 1'b0; req[d] = 1'b0; iaddr[d] = '0;
            len[d] = 1'b0; laddr[d] = '0; ldata[d] = '0;
            last_m[d] = NOP_INSTR;
        end

        tbl[0] = '{1'b1, 32'h0000_0000, 32'h0050_0093, 1'b0};
        tbl[1] = '{1'b1, 32'h0000_0004, 32'h0010_8113, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0008, 32'h0020_8193, 1'b0};
        tbl[3] = '{1'b0, 32'h0000_0000, 32'h0050_0093, 1'b0};
        tbl[4] = '{1'b0, 32'h0000_0004, 32'h0010_8113, 1'b0};
        tbl[5] = '{1'b0, 32'h0000_1000, 32'h0050_0093, 1'b0};
        tbl[6] = '{1'b0, 32'h0000_1003, 32'h0050_0093, 1'b0};
        tbl[7] = '{1'b0, 32'h0000_0000, 32'h0050_0093, 1'b0};
        tbl[8] = '{1'b0, 32'h0000_0004, 32'h0010_8113, 1'b1};
        tbl[9] = '{1'b0, 32'h0000_0008, 32'h0020_8193, 1'b1};

        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("reset gnt %0d", d), {31'b0, gnt[d]}, 32'd0);
            chk($sformatf("reset data %0d", d), idata[d], NOP_INSTR);
            chk($sformatf("reset load_rdy %0d", d), {31'b0, lrdy[d]}, 32'd0);
        end
        for (int d = 0; d < ND; d++) rstz[d] = 1'b1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 10; i++) begin
                if (tbl[i].is_load) load(d, tbl[i].addr, tbl[i].data);
                else fetch(d, tbl[i].addr, tbl[i].data, tbl[i].b2b,
                           $sformatf("tbl%0d_%0d", d, i));
            end
        end

        // Load and fetch to the same word in one cycle: the load lands first.
        @(negedge clk);
        len[0] = 1'b1; laddr[0] = 32'h8; ldata[0] = 32'hDEAD_BEEF;
        req[0] = 1'b1; iaddr[0] = 32'h8;
        @(negedge clk);
        chk("same-cycle load_rdy idle", {31'b0, lrdy[0]}, 32'd1);
        chk("same-cycle no early gnt", {31'b0, gnt[0]}, 32'd0);
        len[0] = 1'b0;
        mem_m[0][2] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("same-cycle load_rdy read", {31'b0, lrdy[0]}, 32'd0);
        chk("same-cycle gnt read", {31'b0, gnt[0]}, 32'd0);
        @(negedge clk);
        chk("same-cycle gnt", {31'b0, gnt[0]}, 32'd1);
        chk("same-cycle data", idata[0], 32'hDEAD_BEEF);
        chk("same-cycle load_rdy resp", {31'b0, lrdy[0]}, 32'd0);
        last_m[0] = 32'hDEAD_BEEF;
        req[0] = 1'b0;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) load(d, 32'(i * 4), $urandom);
            prev_fetch = 1'b0;
            for (int i = 0; i < 60; i++) begin
                a = $urandom;
                a[11:2] = 10'($urandom_range(0, 63));
                if ($urandom_range(0, 3) == 0) begin
                    load(d, a, $urandom);
                    prev_fetch = 1'b0;
                end else begin
                    fetch(d, a, mem_m[d][widx(a)],
                          prev_fetch && ($urandom_range(0, 1) == 1),
                          $sformatf("rnd%0d_%0d", d, i));
                    prev_fetch = 1'b1;
                end
            end
        end

        // Reset while waiting, then while granting, on the LATENCY=5 instance.
        load(2, 32'h10, 32'h00A0_0513);
        load(2, 32'h14, 32'h00B0_0593);
        @(negedge clk);
        req[2] = 1'b1; iaddr[2] = 32'h10;
        repeat (3) @(negedge clk);
        rstz[2] = 1'b0; req[2] = 1'b0;
        #1;
        chk("rst wait gnt", {31'b0, gnt[2]}, 32'd0);
        chk("rst wait data", idata[2], NOP_INSTR);
        chk("rst wait load_rdy", {31'b0, lrdy[2]}, 32'd0);
        last_m[2] = NOP_INSTR;
        @(negedge clk);
        rstz[2] = 1'b1;
        stale = 1'b0;
        repeat (10) begin
            @(negedge clk);
            stale |= gnt[2];
        end
        chk("rst no stale gnt", {31'b0, stale}, 32'd0);
        fetch(2, 32'h10, 32'h00A0_0513, 1'b0, "rst fresh");

        @(negedge clk);
        req[2] = 1'b1; iaddr[2] = 32'h14;
        for (int k = 0; k < 20 && !gnt[2]; k++) @(negedge clk);
        chk("rst resp reached", {31'b0, gnt[2]}, 32'd1);
        rstz[2] = 1'b0; req[2] = 1'b0;
        #1;
        chk("rst resp gnt drop", {31'b0, gnt[2]}, 32'd0);
        chk("rst resp data", idata[2], NOP_INSTR);
        last_m[2] = NOP_INSTR;
        @(negedge clk);
        rstz[2] = 1'b1;
        fetch(2, 32'h14, 32'h00B0_0593, 1'b0, "rst refetch");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
